// File: rtl/prog_ram_pkg.sv
// prog_ram_pkg: shared types and default sizes for the program/data RAM.
//   state_t     : loader FSM encoding (IDLE, LOAD, DONE)
//   DATA_W_DEF  : default word width
//   ADDR_W_DEF  : default address width (depth = 2**ADDR_W)
package prog_ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prog_ram_array.sv
// prog_ram_array: plain single-port storage, synchronous write, no reset on
// contents. The read is combinational from the stored word, so a register that
// captures rdata on the same edge as a write sees the old word (read-first).
//   clk   : clock
//   we    : write enable
//   addr  : word address shared by read and write
//   wdata : write data
//   rdata : word currently stored at addr
module prog_ram_array
  import prog_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/prog_ram.sv
// prog_ram: single-port program/data RAM with a CPU port (registered read,
// valid strobe) and a streaming loader that fills a block of words with
// auto-incrementing, wrapping addresses. The CPU is stalled while the loader
// owns the memory; stalled CPU requests are dropped without side effects.
//   clk, rst                          : clock, async active-low reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata  : CPU request
//   cpu_rdata/cpu_rvalid              : registered read data and strobe
//   cpu_stall                         : loader owns memory
//   ld_start/ld_base/ld_len           : load command (sampled in IDLE only)
//   ld_valid/ld_data/ld_ready         : load data handshake
//   ld_busy/ld_done                   : load status
//
// state | meaning
// IDLE  | CPU owns the memory, waiting for ld_start
// LOAD  | accepting load words, CPU stalled
// DONE  | one-cycle completion pulse, CPU still stalled
module prog_ram
  import prog_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic              hs;
  logic              cpu_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Decoded from state only, so no input reaches ld_ready or cpu_stall.
  assign hs     = ld_valid & (state == LOAD);
  assign cpu_ok = (state == IDLE);

  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    ld_ready  = 1'b0;
    ld_busy   = 1'b0;
    ld_done   = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) state_nxt = (ld_len != '0) ? LOAD : DONE;
      end
      LOAD: begin
        cpu_stall = 1'b1;
        ld_ready  = 1'b1;
        ld_busy   = 1'b1;
        if (hs && cnt == (ADDR_W+1)'(1)) state_nxt = DONE;
      end
      DONE: begin
        cpu_stall = 1'b1;
        ld_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && ld_start) begin
        ptr <= ld_base;
        cnt <= ld_len;
      end else if (hs) begin
        ptr <= ptr + ADDR_W'(1);
        cnt <= cnt - (ADDR_W+1)'(1);
      end
    end
  end

  // Loader owns the port in LOAD; in DONE neither side may write.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (state == LOAD) begin
      mem_we    = hs;
      mem_addr  = ptr;
      mem_wdata = ld_data;
    end else if (cpu_ok) begin
      mem_we = cpu_wr;
    end
  end

  prog_ram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_ok & cpu_rd;
      if (cpu_ok && cpu_rd) cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_prog_ram.sv
// Bench for prog_ram: two instances (8/5 and 16/8) share one stimulus stream
// and are each compared every cycle against a word-level reference model,
// plus a vector table and directed sequences for the multi-cycle cases.
module tb_prog_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_base = '0;
  logic [8:0]  ld_len = '0;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = '0;

  logic [7:0]  rdata_a;
  logic        rvalid_a, stall_a, ready_a, busy_a, done_a;
  logic [15:0] rdata_b;
  logic        rvalid_b, stall_b, ready_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_ram dut_a (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr[4:0]), .cpu_wdata(cpu_wdata[7:0]),
    .cpu_rdata(rdata_a), .cpu_rvalid(rvalid_a), .cpu_stall(stall_a),
    .ld_start(ld_start), .ld_base(ld_base[4:0]), .ld_len(ld_len[5:0]),
    .ld_valid(ld_valid), .ld_data(ld_data[7:0]),
    .ld_ready(ready_a), .ld_busy(busy_a), .ld_done(done_a)
  );

  prog_ram #(.DATA_W(16), .ADDR_W(8)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(rdata_b), .cpu_rvalid(rvalid_b), .cpu_stall(stall_b),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ready_b), .ld_busy(busy_b), .ld_done(done_b)
  );

  // Reference model: memory arrays, words left to load, next load address,
  // pending done pulse, and the CPU read register.
  logic [15:0] m_mem [2][256];
  int          m_rem [2];
  int          m_ptr [2];
  bit          m_done [2];
  logic [15:0] m_rdata [2];
  bit          m_rvalid [2];

  typedef struct {
    logic        start;
    logic [7:0]  base;
    logic [8:0]  len;
    logic        valid;
    logic [15:0] data;
    logic        rd;
    logic [7:0]  addr;
    logic        e_ready, e_done, e_stall, e_rvalid;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[14];
  int   tbl_row = -1;

  function automatic vec_t mk(logic st, logic [7:0] b, logic [8:0] l, logic v, logic [15:0] d,
                              logic r, logic [7:0] a, logic er, logic ed, logic es, logic ev,
                              logic [15:0] erd);
    vec_t x;
    x.start = st; x.base = b; x.len = l; x.valid = v; x.data = d; x.rd = r; x.addr = a;
    x.e_ready = er; x.e_done = ed; x.e_stall = es; x.e_rvalid = ev; x.e_rdata = erd;
    return x;
  endfunction

  task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_ptr[k] = 0; m_done[k] = 0; m_rdata[k] = '0; m_rvalid[k] = 0;
    end
  endtask

  task automatic get_out(input int k, output logic [15:0] rd, output logic [4:0] fl);
    // fl = {rvalid, stall, ready, busy, done}
    if (k == 0) begin
      rd = {8'h00, rdata_a};
      fl = {rvalid_a, stall_a, ready_a, busy_a, done_a};
    end else begin
      rd = rdata_b;
      fl = {rvalid_b, stall_b, ready_b, busy_b, done_b};
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] rd;
      logic [4:0]  fl;
      bit          loading;
      get_out(k, rd, fl);
      loading = (m_rem[k] > 0);
      chk("model_rdata", k, rd, m_rdata[k]);
      chk("model_flags", k, {11'h0, fl},
          {11'h0, m_rvalid[k], loading || m_done[k], loading, loading, m_done[k]});
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int          depth;
      int          a;
      logic [15:0] dm;
      bit          stall;
      bit          nd;
      depth = (k == 0) ? 32 : 256;
      dm    = (k == 0) ? 16'h00FF : 16'hFFFF;
      a     = int'(cpu_addr) % depth;
      stall = (m_rem[k] > 0) || m_done[k];
      nd    = 0;
      if (!rst) begin
        m_rem[k] = 0; m_done[k] = 0; m_rdata[k] = '0; m_rvalid[k] = 0;
      end else begin
        if (!stall) begin
          m_rvalid[k] = cpu_rd;
          if (cpu_rd) m_rdata[k] = m_mem[k][a];
          if (cpu_wr) m_mem[k][a] = cpu_wdata & dm;
          if (ld_start) begin
            if (ld_len == 0) nd = 1;
            else begin
              m_rem[k] = int'(ld_len);
              m_ptr[k] = int'(ld_base) % depth;
            end
          end
        end else begin
          m_rvalid[k] = 0;
          if (m_rem[k] > 0 && ld_valid) begin
            m_mem[k][m_ptr[k]] = ld_data & dm;
            m_ptr[k] = (m_ptr[k] + 1) % depth;
            m_rem[k]--;
            nd = (m_rem[k] == 0);
          end
        end
        m_done[k] = nd;
      end
    end
  endtask

  task automatic tbl_check();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] rd;
      logic [4:0]  fl;
      get_out(k, rd, fl);
      chk($sformatf("vec%0d_flags", tbl_row), k, {11'h0, fl[4:3], fl[2], fl[0]},
          {11'h0, vecs[tbl_row].e_rvalid, vecs[tbl_row].e_stall, vecs[tbl_row].e_ready,
           vecs[tbl_row].e_done});
      chk($sformatf("vec%0d_rdata", tbl_row), k, rd, vecs[tbl_row].e_rdata);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    if (tbl_row >= 0) tbl_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    cpu_rd = 0; cpu_wr = 0; ld_start = 0; ld_valid = 0;
  endtask

  task automatic chk_reset_vals(input string name);
    for (int k = 0; k < 2; k++) begin
      logic [15:0] rd;
      logic [4:0]  fl;
      get_out(k, rd, fl);
      chk({name, "_rdata"}, k, rd, 16'h0000);
      chk({name, "_flags"}, k, {11'h0, fl}, 16'h0000);
    end
  endtask

  task automatic read_chk(input string name, input logic [7:0] addr, input logic [15:0] exp_a);
    cpu_rd = 1; cpu_wr = 0; cpu_addr = addr;
    tick();
    cpu_rd = 0;
    chk(name, 0, {8'h00, rdata_a}, exp_a);
    chk({name, "_rvalid"}, 0, {15'h0, rvalid_a}, 16'h0001);
  endtask

  task automatic load_words(input logic [7:0] base, input logic [8:0] len, input logic [15:0] first);
    ld_start = 1; ld_base = base; ld_len = len;
    tick();
    ld_start = 0;
    for (int i = 0; i < int'(len); i++) begin
      ld_valid = 1; ld_data = first + 16'(i);
      tick();
    end
    ld_valid = 0;
    tick();
  endtask

  initial begin
    logic [15:0] keep2;

    vecs[0]  = mk(1, 3, 4, 0, 16'h00, 0, 0, 0, 0, 0, 0, 16'h00);
    vecs[1]  = mk(0, 0, 0, 1, 16'hA1, 0, 0, 1, 0, 1, 0, 16'h00);
    vecs[2]  = mk(0, 0, 0, 1, 16'hA2, 0, 0, 1, 0, 1, 0, 16'h00);
    vecs[3]  = mk(0, 0, 0, 0, 16'hEE, 0, 0, 1, 0, 1, 0, 16'h00);
    vecs[4]  = mk(0, 0, 0, 0, 16'hEE, 0, 0, 1, 0, 1, 0, 16'h00);
    vecs[5]  = mk(0, 0, 0, 1, 16'hA3, 0, 0, 1, 0, 1, 0, 16'h00);
    vecs[6]  = mk(0, 0, 0, 1, 16'hA4, 0, 0, 1, 0, 1, 0, 16'h00);
    vecs[7]  = mk(0, 0, 0, 1, 16'h55, 1, 3, 0, 1, 1, 0, 16'h00);
    vecs[8]  = mk(0, 0, 0, 0, 16'h00, 1, 3, 0, 0, 0, 0, 16'h00);
    vecs[9]  = mk(0, 0, 0, 0, 16'h00, 1, 4, 0, 0, 0, 1, 16'hA1);
    vecs[10] = mk(0, 0, 0, 0, 16'h00, 1, 5, 0, 0, 0, 1, 16'hA2);
    vecs[11] = mk(0, 0, 0, 0, 16'h00, 1, 6, 0, 0, 0, 1, 16'hA3);
    vecs[12] = mk(0, 0, 0, 0, 16'h00, 0, 0, 0, 0, 0, 1, 16'hA4);
    vecs[13] = mk(0, 0, 0, 0, 16'h00, 0, 0, 0, 0, 0, 0, 16'hA4);

    model_reset();
    #2 rst = 0;
    #2 chk_reset_vals("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;

    // Give every word a known value so later reads are deterministic.
    for (int a = 0; a < 256; a++) begin
      cpu_wr = 1; cpu_addr = 8'(a); cpu_wdata = 16'($urandom);
      tick();
    end
    set_idle();

    // Base 3, length 4 with a two-cycle gap, then reads back.
    for (int i = 0; i < 14; i++) begin
      ld_start = vecs[i].start; ld_base = vecs[i].base; ld_len = vecs[i].len;
      ld_valid = vecs[i].valid; ld_data = vecs[i].data;
      cpu_rd = vecs[i].rd; cpu_addr = vecs[i].addr; cpu_wr = 0;
      tbl_row = i;
      tick();
    end
    tbl_row = -1;
    set_idle();

    // Wrap from DEPTH-1 to 0 on the small instance.
    keep2 = m_mem[0][2];
    load_words(8'd30, 9'd4, 16'd10);
    read_chk("wrap30", 8'd30, 16'd10);
    read_chk("wrap31", 8'd31, 16'd11);
    read_chk("wrap0", 8'd0, 16'd12);
    read_chk("wrap1", 8'd1, 16'd13);
    read_chk("wrap2", 8'd2, keep2);

    // Zero-length load alongside a serviced CPU write.
    ld_start = 1; ld_len = 0; ld_base = 8'd5;
    cpu_wr = 1; cpu_addr = 8'd9; cpu_wdata = 16'h0077;
    tick();
    chk("len0_done", 0, {13'h0, done_a, stall_a, busy_a}, 16'h0006);
    ld_start = 0; cpu_wdata = 16'h0088;
    tick();
    chk("len0_after", 0, {13'h0, done_a, stall_a, busy_a}, 16'h0000);
    set_idle();
    read_chk("len0_wr", 8'd9, 16'h0077);

    // Read and write to the same address in one cycle returns the old word.
    cpu_wr = 1; cpu_addr = 8'd7; cpu_wdata = 16'd11;
    tick();
    cpu_rd = 1; cpu_wdata = 16'd22;
    tick();
    set_idle();
    chk("rdfirst_old", 0, {8'h00, rdata_a}, 16'd11);
    read_chk("rdfirst_new", 8'd7, 16'd22);

    // CPU requests during a load are dropped.
    keep2 = m_mem[0][2];
    ld_start = 1; ld_base = 8'd20; ld_len = 9'd3;
    tick();
    ld_start = 0;
    cpu_wr = 1; cpu_rd = 1; cpu_addr = 8'd2; cpu_wdata = 16'h00FF;
    tick();
    cpu_wr = 0; cpu_rd = 0;
    chk("stall_rvalid", 0, {14'h0, rvalid_a, stall_a}, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = 16'h0040 + 16'(i);
      tick();
    end
    ld_valid = 0;
    tick();
    read_chk("stall_mem2", 8'd2, keep2);

    // Reset after 2 of 5 words.
    ld_start = 1; ld_base = 8'd10; ld_len = 9'd5;
    tick();
    ld_start = 0;
    ld_valid = 1; ld_data = 16'h0031;
    tick();
    ld_data = 16'h0032;
    tick();
    ld_data = 16'h0033;
    #2 rst = 0;
    #1 model_reset();
    chk_reset_vals("midload_rst");
    tick();
    #1 rst = 1;
    ld_valid = 0;
    tick();
    tick();
    tick();
    read_chk("abort10", 8'd10, 16'h0031);
    read_chk("abort11", 8'd11, 16'h0032);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cpu_rd    = 1'($urandom_range(0, 1));
      cpu_wr    = ($urandom_range(0, 2) == 0);
      cpu_addr  = 8'($urandom);
      cpu_wdata = 16'($urandom);
      ld_start  = ($urandom_range(0, 15) == 0);
      ld_base   = 8'($urandom);
      ld_len    = 9'($urandom_range(0, 32));
      ld_valid  = 1'($urandom_range(0, 1));
      ld_data   = 16'($urandom);
      tick();
    end
    set_idle();
    for (int i = 0; i < 40; i++) begin
      ld_valid = 1; ld_data = 16'($urandom);
      tick();
    end
    set_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
